// File: rtl/ext_muldiv.sv
// ext_muldiv: iterative signed multiply/divide for the EX stage.
// The divider datapath is built only when EXT_DIV_EN is defined; otherwise DIV/REM complete in one cycle with result 0.
module ext_muldiv #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_ID_EX,
    input  logic [1:0]       extop_ID_EX,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic             stall_EX_DM,
    output logic             stall_ext,
    output logic [WIDTH-1:0] dst_ext_EX_DM,
    output logic             ext_vld_EX_DM
);
    localparam int CW = $clog2(ITER);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [1:0]           op_q;
    logic                 sign_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [2*WIDTH-1:0]   acc_q, acc_d, prod;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     abs0, abs1, res;
`ifdef EXT_DIV_EN
    logic                 div0_q;
    logic [WIDTH:0]       diff;
`endif
    // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly 2^31.
    assign abs0 = src0[WIDTH-1] ? -src0 : src0;
    assign abs1 = src1[WIDTH-1] ? -src1 : src1;
    assign stall_ext = rst_n && ((state_q == IDLE && start_ID_EX) || state_q == RUN);
    // acc_q holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        acc_d = {sum, acc_q[WIDTH-1:1]};
        prod = sign_q ? -acc_q : acc_q;
        res = op_q[1] ? '0 : (op_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);
`ifdef EXT_DIV_EN
        diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (op_q[1])
            acc_d = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        if (op_q[1])
            res = op_q[0] ? (sign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH])
                          : (div0_q ? '1 : (sign_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]));
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            sign_q        <= 1'b0;
            opnd_q        <= '0;
            acc_q         <= '0;
            dst_ext_EX_DM <= '0;
            ext_vld_EX_DM <= 1'b0;
`ifdef EXT_DIV_EN
            div0_q        <= 1'b0;
`endif
        end else begin
            ext_vld_EX_DM <= 1'b0;
            case (state_q)
                IDLE: if (start_ID_EX) begin
                    op_q   <= extop_ID_EX;
                    sign_q <= extop_ID_EX == 2'b11 ? src0[WIDTH-1] : src0[WIDTH-1] ^ src1[WIDTH-1];
                    opnd_q <= extop_ID_EX[1] ? abs1 : abs0;
                    acc_q  <= {{WIDTH{1'b0}}, extop_ID_EX[1] ? abs0 : abs1};
                    cnt_q  <= '0;
`ifdef EXT_DIV_EN
                    div0_q  <= src1 == '0;
                    state_q <= RUN;
`else
                    state_q <= extop_ID_EX[1] ? DONE : RUN;
`endif
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1))
                        state_q <= DONE;
                end
                DONE: if (!stall_EX_DM) begin
                    dst_ext_EX_DM <= res;
                    ext_vld_EX_DM <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ext_muldiv.sv
// tb_ext_muldiv: directed vectors with a result scoreboard for ext_muldiv.
module tb_ext_muldiv;
`ifdef EXT_DIV_EN
    localparam bit DE = 1'b1;
    localparam int DS = 33;
`else
    localparam bit DE = 1'b0;
    localparam int DS = 1;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall_dm = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        stall_ext, vld;
    logic [31:0] dst;
    logic [31:0] exp_q[$];
    int          vld_cycles[$];
    int          cyc = 0, n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ext_muldiv dut (
        .clk(clk), .rst_n(rst_n), .start_ID_EX(start), .extop_ID_EX(op),
        .src0(a), .src1(b), .stall_EX_DM(stall_dm), .stall_ext(stall_ext),
        .dst_ext_EX_DM(dst), .ext_vld_EX_DM(vld)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vld) begin
            vld_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_vld: got result %h with nothing expected", dst);
            end else
                chk("result", dst, exp_q.pop_front());
        end
    end

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] e, input int st, input bit hold);
        int n = 0;
        logic [31:0] prev;
        @(posedge clk);
        #1;
        op = o; a = x; b = y; start = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_ext) break;
            n++;
            if (n == 2) begin a = ~x; b = ~y; end
        end
        start = 1'b0;
        chk({nm, "_stall_cycles"}, 32'(n), 32'(st));
        prev = dst;
        if (hold) begin
            stall_dm = 1'b1;
            repeat (5) begin
                @(negedge clk);
                chk({nm, "_hold_vld"}, 32'(vld), 32'd0);
                chk({nm, "_hold_dst"}, dst, prev);
                chk({nm, "_hold_stall_ext"}, 32'(stall_ext), 32'd0);
            end
            stall_dm = 1'b0;
            @(negedge clk);
            chk({nm, "_release_vld"}, 32'(vld), 32'd1);
        end
    endtask

    initial begin
        start = 1'b1;
        #12;
        chk("reset_dst", dst, 32'd0);
        chk("reset_vld", 32'(vld), 32'd0);
        chk("reset_stall_ext", 32'(stall_ext), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        run_op("mul_7_m3",   2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
        run_op("mulh_7_m3",  2'b01, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
        run_op("mulh_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1'b0);
        run_op("mul_min",    2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 33, 1'b1);
        run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, DE ? 32'hFFFFFFFD : 32'd0, DS, 1'b0);
        run_op("rem_m7_2",   2'b11, 32'hFFFFFFF9, 32'd2, DE ? 32'hFFFFFFFF : 32'd0, DS, 1'b0);
        run_op("div_100_0",  2'b10, 32'd100, 32'd0, DE ? 32'hFFFFFFFF : 32'd0, DS, 1'b0);
        run_op("rem_100_0",  2'b11, 32'd100, 32'd0, DE ? 32'd100 : 32'd0, DS, 1'b0);
        run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, DE ? 32'h80000000 : 32'd0, DS, 1'b0);
        run_op("rem_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0, DS, 1'b0);
        run_op("div_9_3",    2'b10, 32'd9, 32'd3, DE ? 32'd3 : 32'd0, DS, 1'b1);
        run_op("b2b_2x2",    2'b00, 32'd2, 32'd2, 32'd4, 33, 1'b0);
        run_op("b2b_5x5",    2'b00, 32'd5, 32'd5, 32'd25, 33, 1'b0);
        @(negedge clk);
        #1;
        if (vld_cycles.size() >= 2)
            chk("b2b_spacing", 32'(vld_cycles[$] - vld_cycles[$-1]), 32'd34);
        else begin
            n_chk++;
            n_fail++;
            $display("FAIL b2b_spacing: got %0d results expected at least 2", vld_cycles.size());
        end
        // Abort a MUL mid-iteration; its result must never appear.
        @(posedge clk);
        #1;
        op = 2'b00; a = 32'd5; b = 32'd6; start = 1'b1;
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_dst", dst, 32'd0);
        chk("midrun_reset_vld", 32'(vld), 32'd0);
        chk("midrun_reset_stall_ext", 32'(stall_ext), 32'd0);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("mul_3x4_after_reset", 2'b00, 32'd3, 32'd4, 32'd12, 33, 1'b0);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
